// File: rtl/regfile_pkg.sv
// Shared register-file definitions: widths, the hard-wired zero register and
// the writeback entry layout used by the datapath, the writeback queue and
// the register file itself.
package regfile_pkg;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    // Register 0 reads as zero; writes to it are dropped.
    localparam logic [ADDR_W-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } wb_entry_t;
endpackage

// File: rtl/wbq_fifo.sv
// Writeback queue storage: DEPTH-entry circular buffer with head/tail pointers
// and an occupancy count.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   push, push_rd/data  enqueue one entry at the tail
//   pop                 retire the head entry
//   age_vld/rd/data     entries in age order, [0] = head (oldest)
//   count               occupancy, 0..DEPTH
// The caller never pushes into a full queue unless it pops in the same cycle.
module wbq_fifo #(
    parameter  int DEPTH  = 4,
    parameter  int DATA_W = 32,
    parameter  int ADDR_W = 5,
    localparam int PW     = $clog2(DEPTH),
    localparam int CW     = PW + 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           push,
    input  logic [ADDR_W-1:0]              push_rd,
    input  logic [DATA_W-1:0]              push_data,
    input  logic                           pop,
    output logic [DEPTH-1:0]               age_vld,
    output logic [DEPTH-1:0][ADDR_W-1:0]   age_rd,
    output logic [DEPTH-1:0][DATA_W-1:0]   age_data,
    output logic [CW-1:0]                  count
);
    logic [DEPTH-1:0][ADDR_W-1:0] mem_rd;
    logic [DEPTH-1:0][DATA_W-1:0] mem_data;
    logic [PW-1:0]                head;
    logic [PW-1:0]                tail;

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            mem_rd   <= '0;
            mem_data <= '0;
        end else begin
            if (push) begin
                mem_rd[tail]   <= push_rd;
                mem_data[tail] <= push_data;
                tail           <= tail + 1'b1;
            end
            if (pop)
                head <= head + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Rotate storage into age order so the bypass chains need no pointer math.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            age_vld[i]  = CW'(i) < count;
            age_rd[i]   = mem_rd[head + PW'(i)];
            age_data[i] = mem_data[head + PW'(i)];
        end
    end
endmodule

// File: rtl/regfile_wb_queue.sv
// Write-side initiator for the register file. Buffers writeback requests and
// issues one per cycle on the file's single write port, holding the head while
// the port is stalled. Pending writes are visible to the read ports through a
// combinational bypass lookup so reads never see stale data.
// Ports:
//   in_valid/in_ready/in_rd/in_data  writeback request handshake
//   rf_stall                         write port busy; hold the head entry
//   wr/Rw/busW                       register-file write port (file writes on negedge)
//   Ra/Rb                            read addresses for bypass lookup
//   hitA/hitB, byA/byB               bypass hit and youngest matching data
//   count                            queue occupancy
module regfile_wb_queue #(
    parameter  int DEPTH  = 4,
    parameter  int DATA_W = regfile_pkg::DATA_W,
    parameter  int ADDR_W = regfile_pkg::ADDR_W,
    localparam int CW     = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_rd,
    input  logic [DATA_W-1:0] in_data,
    input  logic              rf_stall,
    output logic              wr,
    output logic [ADDR_W-1:0] Rw,
    output logic [DATA_W-1:0] busW,
    input  logic [ADDR_W-1:0] Ra,
    input  logic [ADDR_W-1:0] Rb,
    output logic              hitA,
    output logic              hitB,
    output logic [DATA_W-1:0] byA,
    output logic [DATA_W-1:0] byB,
    output logic [CW-1:0]     count
);
    import regfile_pkg::*;

    localparam logic [CW-1:0]     FULL = CW'(DEPTH);
    localparam logic [ADDR_W-1:0] RZ   = ADDR_W'(REG_ZERO);

    logic                         accept;
    logic                         drain;
    logic                         push;
    logic [DEPTH-1:0]             age_vld;
    logic [DEPTH-1:0][ADDR_W-1:0] age_rd;
    logic [DEPTH-1:0][DATA_W-1:0] age_data;

    assign drain    = (count != '0) && !rf_stall;
    // A full queue still accepts when the head leaves in the same cycle.
    assign in_ready = (count < FULL) || drain;
    assign accept   = in_valid && in_ready;
    // Writes to x0 are consumed here and never reach the file.
    assign push     = accept && (in_rd != RZ);

    // The file sees no write during a reset cycle even if entries were pending.
    assign wr   = drain && rst_n;
    assign Rw   = age_vld[0] ? age_rd[0]   : '0;
    assign busW = age_vld[0] ? age_data[0] : '0;

    wbq_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_rd   (in_rd),
        .push_data (in_data),
        .pop       (drain),
        .age_vld   (age_vld),
        .age_rd    (age_rd),
        .age_data  (age_data),
        .count     (count)
    );

    // Scan oldest to youngest so a later match overrides an earlier one. The
    // head stays in the scan until its drain posedge, covering the negedge
    // write window.
    always_comb begin
        hitA = 1'b0;
        hitB = 1'b0;
        byA  = '0;
        byB  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (age_vld[i] && (Ra != RZ) && (age_rd[i] == Ra)) begin
                hitA = 1'b1;
                byA  = age_data[i];
            end
            if (age_vld[i] && (Rb != RZ) && (age_rd[i] == Rb)) begin
                hitB = 1'b1;
                byB  = age_data[i];
            end
        end
    end
endmodule
